// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Fetches one instruction at a time from the instruction memory. It never has
// more than one request in flight. The fetched word is held toward the decode
// stage until decode accepts it. Branch, jump and trap redirects take priority
// over every other transition. They retarget the PC and throw away any
// response that was fetched from the old path.
//
// Sequence with zero-wait memory: REQ -> WAIT -> HOLD -> REQ.
// This gives one instruction every three cycles.
//
// Configuration macro: IFU_MISALIGN_CHK_EN
//   defined   : a redirect to a non word-aligned target enters FAULT. FAULT
//               raises misalign and issues no fetches until an aligned
//               redirect arrives.
//   undefined : there is no misalign port and no FAULT state. Redirect
//               targets are word-aligned by clearing their two low bits.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   imem_req_*      fetch request (valid/ready, address = current PC)
//   imem_rsp_*      fetch response (always accepted)
//   if_*            fetched instruction + PC toward decode (valid/ready)
//   redirect_*      redirect request and target PC
//   misalign        misaligned-target fault flag (macro builds only)
// ---------------------------------------------------------------------------
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [63:0]       if_pc,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic              misalign
`endif
);

`ifdef IFU_MISALIGN_CHK_EN
  typedef enum logic [2:0] {REQ, WAIT, HOLD, DROP, FAULT} state_t;
`else
  typedef enum logic [2:0] {REQ, WAIT, HOLD, DROP} state_t;
`endif

  state_t      state;
  logic [63:0] pc;

  // Sequential next PC. Wraps naturally at 2^64.
  function automatic logic [63:0] seqPc(input logic [63:0] p);
    return p + 64'd4;
  endfunction

  // PC value loaded on a redirect. With the misalignment check enabled, the
  // target is kept as given so the faulting address stays visible.
  function automatic logic [63:0] loadPc(input logic [63:0] p);
`ifdef IFU_MISALIGN_CHK_EN
    return p;
`else
    return p & ~64'd3;
`endif
  endfunction

  // State reached on an aligned redirect from each state.
  // WAIT leaves for DROP when its response is still outstanding, so that
  // response is swallowed later. If the response lands in the same cycle as
  // the redirect, nothing is outstanding, so WAIT can restart immediately.
  function automatic state_t redirectTarget(input state_t s, input logic rspValid);
    state_t n;
    case (s)
      REQ:     n = REQ;
      WAIT:    n = rspValid ? REQ : DROP;
      HOLD:    n = REQ;
      DROP:    n = DROP;
      default: n = REQ;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= REQ;
      pc      <= RESET_PC;
      if_inst <= '0;
      if_pc   <= '0;
    end else if (redirect_valid) begin
      pc <= loadPc(redirect_pc);
`ifdef IFU_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state <= FAULT;
      end else begin
        state <= redirectTarget(state, imem_rsp_valid);
      end
`else
      state <= redirectTarget(state, imem_rsp_valid);
`endif
    end else begin
      case (state)
        REQ: begin
          if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if_inst <= imem_rsp_data;
            if_pc   <= pc;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (if_ready) begin
            pc    <= seqPc(pc);
            state <= REQ;
          end
        end
        DROP: begin
          // The response belongs to the abandoned path; discard it.
          if (imem_rsp_valid) begin
            state <= REQ;
          end
        end
        default: begin
          // FAULT: wait for an aligned redirect.
          state <= state;
        end
      endcase
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;

  // A redirect in HOLD must not let the held word transfer in that cycle.
  assign if_valid = (state == HOLD) && !redirect_valid;

`ifdef IFU_MISALIGN_CHK_EN
  assign misalign = (state == FAULT);
`endif

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu.
// It contains a memory model with a programmable response latency. It keeps
// two scoreboards: one for the expected request addresses and one for the
// expected PCs transferred to decode. Instruction words are derived from
// their address, so every transferred word can be checked against its PC.
// ---------------------------------------------------------------------------
module tb_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          INST_W   = 32;

  logic              clk;
  logic              rst;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [63:0]       imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              if_valid;
  logic              if_ready;
  logic [INST_W-1:0] if_inst;
  logic [63:0]       if_pc;
  logic              redirect_valid;
  logic [63:0]       redirect_pc;
`ifdef IFU_MISALIGN_CHK_EN
  logic              misalign;
`endif

  ifu #(.RESET_PC(RESET_PC), .INST_W(INST_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .misalign       (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  logic [63:0] expAddr[$];
  logic [63:0] expPc[$];
  int          reqCyc[$];
  int          cycNum = 0;
  int          xfers = 0;

  // memory model state
  bit          pend = 1'b0;
  logic [63:0] pendAddr = '0;
  int          cnt = 0;
  int          lat = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [INST_W-1:0] memWord(input logic [63:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // One clock cycle. On entry the time is just after a rising edge and the
  // inputs for this cycle are already set. Outputs are observed mid-cycle.
  task automatic cycle();
    bit delivered;
    logic [63:0] a;
    delivered = pend && (cnt == 0);
    imem_rsp_valid = delivered;
    imem_rsp_data  = delivered ? memWord(pendAddr) : '0;
    #1;
    if (delivered) pend = 1'b0;
    else if (pend) cnt--;
    if (!rst && imem_req_valid && imem_req_ready) begin
      chk("oneOutstanding", {63'd0, pend}, 64'd0);
      chk("reqExpected", 64'(expAddr.size() != 0), 64'd1);
      if (expAddr.size() != 0) begin
        a = expAddr.pop_front();
        chk("reqAddr", imem_req_addr, a);
      end
      pend     = 1'b1;
      pendAddr = imem_req_addr;
      cnt      = lat - 1;
      reqCyc.push_back(cycNum);
    end
    if (!rst && if_valid && if_ready) begin
      chk("xferExpected", 64'(expPc.size() != 0), 64'd1);
      if (expPc.size() != 0) begin
        a = expPc.pop_front();
        chk("ifPc", if_pc, a);
        chk("ifInst", 64'(if_inst), 64'(memWord(a)));
      end
      xfers++;
    end
    @(posedge clk);
    #1;
    cycNum++;
  endtask

  task automatic waitXfer();
    int start;
    int budget;
    start  = xfers;
    budget = 30;
    while (xfers == start && budget > 0) begin
      cycle();
      budget--;
    end
    chk("xferTimeout", 64'(xfers), 64'(start + 1));
  endtask

  task automatic runXfer(input logic [63:0] a);
    expAddr.push_back(a);
    expPc.push_back(a);
    imem_req_ready = 1'b1;
    waitXfer();
    imem_req_ready = 1'b0;
  endtask

  initial begin
    int c0;
    int budget;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rstIfValid", {63'd0, if_valid}, 64'd0);
    chk("rstIfInst", 64'(if_inst), 64'd0);
    chk("rstIfPc", if_pc, 64'd0);
    chk("rstPc", imem_req_addr, RESET_PC);
`ifdef IFU_MISALIGN_CHK_EN
    chk("rstMisalign", {63'd0, misalign}, 64'd0);
`endif
    rst = 1'b0;

    // back-to-back fetches with zero-wait memory
    c0 = cycNum;
    if_ready = 1'b1;
    lat = 1;
    runXfer(64'h8000_0000);
    runXfer(64'h8000_0004);
    runXfer(64'h8000_0008);
    chk("reqCount", 64'(reqCyc.size()), 64'd3);
    if (reqCyc.size() >= 3) begin
      chk("firstReqCyc", 64'(reqCyc[0]), 64'(c0));
      chk("reqGap1", 64'(reqCyc[1]), 64'(c0 + 3));
      chk("reqGap2", 64'(reqCyc[2]), 64'(c0 + 6));
    end

    // decode stall in HOLD
    if_ready = 1'b0;
    expAddr.push_back(64'h8000_000C);
    expPc.push_back(64'h8000_000C);
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    cycle();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stallValid", {63'd0, if_valid}, 64'd1);
      chk("stallPc", if_pc, 64'h8000_000C);
      chk("stallInst", 64'(if_inst), 64'(memWord(64'h8000_000C)));
      chk("stallNoReq", {63'd0, imem_req_valid}, 64'd0);
      cycle();
    end
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    waitXfer();

    // redirect in WAIT, stale response two cycles later
    lat = 3;
    expAddr.push_back(64'h8000_0010);
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    cycle();
    redirect_valid = 1'b0;
    budget = 10;
    while (pend && budget > 0) begin
      cycle();
      budget--;
    end
    chk("staleRspSeen", {63'd0, pend}, 64'd0);
    chk("redirReqValid", {63'd0, imem_req_valid}, 64'd1);
    chk("redirReqAddr", imem_req_addr, 64'h8000_0100);
    lat = 1;
    runXfer(64'h8000_0100);

    // redirect and decode ready together in HOLD
    if_ready = 1'b0;
    expAddr.push_back(64'h8000_0104);
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    cycle();
    chk("holdValid", {63'd0, if_valid}, 64'd1);
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    #1;
    chk("redirKillsValid", {63'd0, if_valid}, 64'd0);
    cycle();
    redirect_valid = 1'b0;
    chk("holdRedirAddr", imem_req_addr, 64'h8000_0300);
    runXfer(64'h8000_0300);

    // reset while a fetch is in flight
    lat = 2;
    expAddr.push_back(64'h8000_0304);
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midRstValid", {63'd0, if_valid}, 64'd0);
    chk("midRstIfPc", if_pc, 64'd0);
    chk("midRstInst", 64'(if_inst), 64'd0);
    chk("midRstPc", imem_req_addr, RESET_PC);
    cycle();
    rst = 1'b0;
    cycle();
    chk("postRstStale", {63'd0, if_valid}, 64'd0);
    chk("postRstAddr", imem_req_addr, RESET_PC);
    lat = 1;
    runXfer(RESET_PC);

    // misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    cycle();
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("faultMisalign", {63'd0, misalign}, 64'd1);
      chk("faultNoReq", {63'd0, imem_req_valid}, 64'd0);
      cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0106;
    cycle();
    chk("faultStays", {63'd0, misalign}, 64'd1);
    redirect_pc    = 64'h8000_0200;
    cycle();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    chk("faultCleared", {63'd0, misalign}, 64'd0);
    chk("faultExitAddr", imem_req_addr, 64'h8000_0200);
    runXfer(64'h8000_0200);
`else
    chk("alignedAddr", imem_req_addr, 64'h8000_0100);
    runXfer(64'h8000_0100);
`endif

    chk("reqQueueEmpty", 64'(expAddr.size()), 64'd0);
    chk("xferQueueEmpty", 64'(expPc.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
